// File: rtl/cpu_sched_pkg.sv
// Shared types and sizing for the execute-stage scheduler and its forwarding unit.
`ifndef NUM_REGS
`define NUM_REGS 32
`endif

package cpu_sched_pkg;

   localparam int NUM_REGS_DEF = `NUM_REGS;
   localparam int REG_ID_W     = $clog2(NUM_REGS_DEF);

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MUL      = 2'd1,
      MEM_WAIT = 2'd2
   } sched_state_e;

   typedef enum logic [1:0] {
      FWD_RF = 2'b00,
      FWD_CM = 2'b01,
      FWD_WB = 2'b10
   } fwd_sel_e;

endpackage

// File: rtl/cpu_execute_scheduler_forward.sv
// Combinational ra/rb operand bypass select; commit result beats writeback result.
module cpu_forward_unit
   import cpu_sched_pkg::*;
#(
   parameter int ID_W = REG_ID_W
) (
   input  logic [ID_W-1:0] ex_ra_id,
   input  logic [ID_W-1:0] ex_rb_id,
   input  logic            cm_valid,
   input  logic            cm_reg_write,
   input  logic [ID_W-1:0] cm_reg_dest,
   input  logic            wb_reg_write,
   input  logic [ID_W-1:0] wb_reg_dest,
   output fwd_sel_e        fwd_a_sel,
   output fwd_sel_e        fwd_b_sel
);

   function automatic fwd_sel_e pick(input logic [ID_W-1:0] src);
      if (cm_valid && cm_reg_write && (cm_reg_dest == src))
         return FWD_CM;
      else if (wb_reg_write && (wb_reg_dest == src))
         return FWD_WB;
      else
         return FWD_RF;
   endfunction

   always_comb begin
      fwd_a_sel = pick(ex_ra_id);
      fwd_b_sel = pick(ex_rb_id);
   end

endmodule

// File: rtl/cpu_execute_scheduler.sv
// Execute-stage pipeline controller: stall/hold/bubble/flush generation for
// load-use, multi-cycle ALU ops, commit-stage cache misses and taken branches.
module cpu_execute_scheduler
   import cpu_sched_pkg::*;
#(
   parameter  int NUM_REGS    = `NUM_REGS,
   parameter  int MUL_LATENCY = 4,
   localparam int ID_W        = $clog2(NUM_REGS)
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            dec_valid,
   input  logic [ID_W-1:0] dec_ra_id,
   input  logic [ID_W-1:0] dec_rb_id,
   input  logic            dec_use_rb,
   input  logic            ex_valid,
   input  logic [ID_W-1:0] ex_ra_id,
   input  logic [ID_W-1:0] ex_rb_id,
   input  logic [ID_W-1:0] ex_reg_dest,
   input  logic            ex_reg_write,
   input  logic            ex_mem_read,
   input  logic            ex_multicycle,
   input  logic            branch_taken,
   input  logic            cm_valid,
   input  logic [ID_W-1:0] cm_reg_dest,
   input  logic            cm_reg_write,
   input  logic            cm_mem_req,
   input  logic            dcache_ready,
   input  logic [ID_W-1:0] wb_reg_dest,
   input  logic            wb_reg_write,
   output logic            stall_fetch,
   output logic            stall_decode,
   output logic            hold_execute,
   output logic            bubble_execute,
   output logic            stall_commit,
   output logic            bubble_writeback,
   output logic            flush_decode,
   output logic [1:0]      fwd_a_sel,
   output logic [1:0]      fwd_b_sel,
   output logic            mul_busy
);

   localparam int              CNT_W    = $clog2(MUL_LATENCY + 1);
   localparam logic            MUL_EN   = (MUL_LATENCY > 1);
   localparam logic            MUL_FSM  = (MUL_LATENCY > 2);
   localparam logic [CNT_W-1:0] CNT_LOAD = MUL_FSM ? CNT_W'(MUL_LATENCY - 2) : '0;

   sched_state_e     state_q, state_d, ret_q, ret_d, eff_state;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             done_q, done_d;
   logic             mem_miss, mem_stall, run_ok;
   logic             mul_start, mul_hold, br_flush, lu_hazard, lu_stall;
   fwd_sel_e         fa_sel, fb_sel;

   // The cycle dcache_ready returns already behaves as the saved state, so a
   // hazard or MUL step present in that cycle is not lost.
   always_comb begin
      mem_miss  = cm_valid & cm_mem_req & ~dcache_ready;
      mem_stall = mem_miss | ((state_q == MEM_WAIT) & ~dcache_ready);
      eff_state = ((state_q == MEM_WAIT) && dcache_ready) ? ret_q : state_q;
      run_ok    = (eff_state == RUN) & ~mem_stall;
      // done_q keeps a just-finished MUL op from re-triggering on its completion cycle
      mul_start = run_ok & MUL_EN & ex_valid & ex_multicycle & ~done_q;
      mul_hold  = mul_start | (eff_state == MUL);
      br_flush  = run_ok & ~mul_start & branch_taken;
      lu_hazard = dec_valid & ex_valid & ex_mem_read & ex_reg_write &
                  ((dec_ra_id == ex_reg_dest) | (dec_use_rb & (dec_rb_id == ex_reg_dest)));
      lu_stall  = run_ok & ~mul_start & ~branch_taken & lu_hazard;
   end

   always_comb begin
      stall_fetch      = mem_stall | mul_hold | lu_stall;
      stall_decode     = mem_stall | mul_hold | lu_stall;
      hold_execute     = mem_stall | mul_hold;
      bubble_execute   = br_flush | lu_stall;
      stall_commit     = mem_stall;
      bubble_writeback = mem_stall;
      flush_decode     = br_flush;
      mul_busy         = mul_hold;
   end

   always_comb begin
      state_d = state_q;
      ret_d   = ret_q;
      cnt_d   = cnt_q;
      done_d  = done_q;
      if (mem_stall) begin
         // counter stays frozen; remember where to resume
         state_d = MEM_WAIT;
         if (state_q != MEM_WAIT) ret_d = state_q;
      end else begin
         state_d = eff_state;
         case (eff_state)
            RUN: begin
               done_d = 1'b0;
               if (mul_start) begin
                  if (MUL_FSM) begin
                     state_d = MUL;
                     cnt_d   = CNT_LOAD;
                  end else begin
                     done_d = 1'b1;
                  end
               end
            end
            MUL: begin
               cnt_d = cnt_q - 1'b1;
               if (cnt_d == '0) begin
                  state_d = RUN;
                  done_d  = 1'b1;
               end
            end
            default: state_d = RUN;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= RUN;
         ret_q   <= RUN;
         cnt_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ret_q   <= ret_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
      end
   end

   cpu_forward_unit #(.ID_W(ID_W)) u_fwd (
      .ex_ra_id    (ex_ra_id),
      .ex_rb_id    (ex_rb_id),
      .cm_valid    (cm_valid),
      .cm_reg_write(cm_reg_write),
      .cm_reg_dest (cm_reg_dest),
      .wb_reg_write(wb_reg_write),
      .wb_reg_dest (wb_reg_dest),
      .fwd_a_sel   (fa_sel),
      .fwd_b_sel   (fb_sel)
   );

   assign fwd_a_sel = fa_sel;
   assign fwd_b_sel = fb_sel;

endmodule

// File: tb/tb_cpu_execute_scheduler.sv
// Scoreboard bench: each driven cycle pushes its expected control vector, popped at the negedge.
module tb_cpu_execute_scheduler;

   localparam int ID_W = 5;

   // packed view: {sf,sd,he,be,sc,bw,fd,fa[1:0],fb[1:0],mb}
   localparam logic [11:0] O_SF = 12'h800, O_SD = 12'h400, O_HE = 12'h200, O_BE = 12'h100;
   localparam logic [11:0] O_SC = 12'h080, O_BW = 12'h040, O_FD = 12'h020, O_MB = 12'h001;
   localparam logic [11:0] FA_CM = 12'h008, FA_WB = 12'h010, FB_CM = 12'h002, FB_WB = 12'h004;
   localparam logic [11:0] LU   = O_SF | O_SD | O_BE;
   localparam logic [11:0] MULH = O_SF | O_SD | O_HE | O_MB;
   localparam logic [11:0] MEM  = O_SF | O_SD | O_HE | O_SC | O_BW;
   localparam logic [11:0] BR   = O_FD | O_BE;

   logic clk, reset;
   logic dec_valid, dec_use_rb, ex_valid, ex_reg_write, ex_mem_read, ex_multicycle, branch_taken;
   logic cm_valid, cm_reg_write, cm_mem_req, dcache_ready, wb_reg_write;
   logic [ID_W-1:0] dec_ra_id, dec_rb_id, ex_ra_id, ex_rb_id, ex_reg_dest, cm_reg_dest, wb_reg_dest;
   logic stall_fetch, stall_decode, hold_execute, bubble_execute, stall_commit;
   logic bubble_writeback, flush_decode, mul_busy;
   logic [1:0] fwd_a_sel, fwd_b_sel;

   int checks = 0;
   int failures = 0;
   logic [11:0] exp_q[$];

   cpu_execute_scheduler #(.NUM_REGS(32), .MUL_LATENCY(4)) dut (
      .clk(clk), .reset(reset),
      .dec_valid(dec_valid), .dec_ra_id(dec_ra_id), .dec_rb_id(dec_rb_id), .dec_use_rb(dec_use_rb),
      .ex_valid(ex_valid), .ex_ra_id(ex_ra_id), .ex_rb_id(ex_rb_id), .ex_reg_dest(ex_reg_dest),
      .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_multicycle(ex_multicycle),
      .branch_taken(branch_taken),
      .cm_valid(cm_valid), .cm_reg_dest(cm_reg_dest), .cm_reg_write(cm_reg_write),
      .cm_mem_req(cm_mem_req), .dcache_ready(dcache_ready),
      .wb_reg_dest(wb_reg_dest), .wb_reg_write(wb_reg_write),
      .stall_fetch(stall_fetch), .stall_decode(stall_decode), .hold_execute(hold_execute),
      .bubble_execute(bubble_execute), .stall_commit(stall_commit),
      .bubble_writeback(bubble_writeback), .flush_decode(flush_decode),
      .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .mul_busy(mul_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [11:0] got, input logic [11:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %03h expected %03h", tag, got, exp);
      end
   endtask

   task automatic cyc(input string tag, input logic [11:0] e);
      logic [11:0] got;
      exp_q.push_back(e);
      @(negedge clk);
      got = {stall_fetch, stall_decode, hold_execute, bubble_execute, stall_commit,
             bubble_writeback, flush_decode, fwd_a_sel, fwd_b_sel, mul_busy};
      chk(tag, got, exp_q.pop_front());
      @(posedge clk); #1;
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic clr();
      dec_valid = 0; dec_use_rb = 0; ex_valid = 0; ex_reg_write = 0; ex_mem_read = 0;
      ex_multicycle = 0; branch_taken = 0; cm_valid = 0; cm_reg_write = 0; cm_mem_req = 0;
      dcache_ready = 0; wb_reg_write = 0;
      dec_ra_id = 0; dec_rb_id = 0; ex_ra_id = 0; ex_rb_id = 0; ex_reg_dest = 0;
      cm_reg_dest = 0; wb_reg_dest = 0;
   endtask

   task automatic set_load(input logic [ID_W-1:0] dst);
      ex_valid = 1; ex_mem_read = 1; ex_reg_write = 1; ex_reg_dest = dst;
   endtask

   initial begin
      clr();
      ex_ra_id = 5'd20; ex_rb_id = 5'd21;
      reset = 1;
      tick();
      cyc("reset", 12'h000);
      reset = 0;
      cyc("idle", 12'h000);

      // load-use: ex ld r3, dec add r1,r3,r4
      set_load(5'd3); dec_valid = 1; dec_ra_id = 5'd3; dec_rb_id = 5'd4; dec_use_rb = 1;
      cyc("lu_ra", LU);
      ex_valid = 0; ex_mem_read = 0;
      cyc("lu_release", 12'h000);
      set_load(5'd3); dec_ra_id = 5'd7; dec_rb_id = 5'd3; dec_use_rb = 0;
      cyc("lu_rb_unused", 12'h000);
      dec_use_rb = 1;
      cyc("lu_rb", LU);
      set_load(5'd0); dec_ra_id = 5'd0; dec_rb_id = 5'd9;
      cyc("lu_r0", LU);

      // branch wins over load-use
      branch_taken = 1;
      cyc("br_over_lu", BR);
      clr(); ex_ra_id = 5'd20; ex_rb_id = 5'd21;
      cyc("br_release", 12'h000);

      // MUL_LATENCY=4, back-to-back
      ex_valid = 1; ex_multicycle = 1; ex_reg_write = 1; ex_reg_dest = 5'd9;
      cyc("mul1_t0", MULH);
      cyc("mul1_t1", MULH);
      cyc("mul1_t2", MULH);
      cyc("mul1_done", 12'h000);
      cyc("mul2_t0", MULH);
      cyc("mul2_t1", MULH);
      cyc("mul2_t2", MULH);
      cyc("mul2_done", 12'h000);
      ex_valid = 0; ex_multicycle = 0;
      cyc("mul_idle", 12'h000);

      // cache miss for 5 cycles
      cm_valid = 1; cm_mem_req = 1; dcache_ready = 0;
      for (int i = 0; i < 5; i++) cyc($sformatf("miss_%0d", i), MEM);
      dcache_ready = 1;
      cyc("miss_exit", 12'h000);
      cm_valid = 0; cm_mem_req = 0;
      cyc("miss_idle", 12'h000);

      // miss arriving during MUL at count 1
      ex_valid = 1; ex_multicycle = 1; dcache_ready = 0;
      cyc("mm_t0", MULH);
      cyc("mm_t1", MULH);
      cm_valid = 1; cm_mem_req = 1;
      cyc("mm_arrive", MEM | O_MB);
      cyc("mm_wait0", MEM);
      cyc("mm_wait1", MEM);
      dcache_ready = 1;
      cyc("mm_resume", MULH);
      cm_valid = 0; cm_mem_req = 0;
      cyc("mm_done", 12'h000);
      ex_valid = 0; ex_multicycle = 0;
      cyc("mm_idle", 12'h000);

      // forwarding
      cm_valid = 1; cm_reg_write = 1; cm_reg_dest = 5'd5;
      wb_reg_write = 1; wb_reg_dest = 5'd5; ex_ra_id = 5'd5; ex_rb_id = 5'd6;
      cyc("fwd_cm_a", FA_CM);
      cm_reg_write = 0;
      cyc("fwd_wb_a", FA_WB);
      ex_rb_id = 5'd5;
      cyc("fwd_wb_ab", FA_WB | FB_WB);
      cm_reg_write = 1; cm_valid = 0;
      cyc("fwd_cm_invalid", FA_WB | FB_WB);
      cm_valid = 1;
      cyc("fwd_cm_ab", FA_CM | FB_CM);
      cm_mem_req = 1; dcache_ready = 0;
      cyc("fwd_in_stall", MEM | FA_CM | FB_CM);
      dcache_ready = 1;
      cyc("fwd_stall_exit", FA_CM | FB_CM);
      clr(); ex_ra_id = 5'd20; ex_rb_id = 5'd21;
      cyc("fwd_idle", 12'h000);

      // reset during MEM_WAIT (state holds stalls even with cm inputs dropped)
      cm_valid = 1; cm_mem_req = 1; dcache_ready = 0;
      cyc("rst_mem_enter", MEM);
      cm_valid = 0; cm_mem_req = 0;
      cyc("rst_mem_state", MEM);
      reset = 1; tick(); reset = 0;
      cyc("rst_mem_after", 12'h000);

      // reset during MUL
      ex_valid = 1; ex_multicycle = 1;
      cyc("rst_mul_t0", MULH);
      ex_valid = 0; ex_multicycle = 0;
      cyc("rst_mul_state", MULH);
      reset = 1; tick(); reset = 0;
      cyc("rst_mul_after", 12'h000);
      cyc("rst_mul_quiet", 12'h000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
